// File: rtl/if_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Holds the NOP filler word and the RUN/HALT fetch state codes.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IF_RUN  = 1'b0,
        IF_HALT = 1'b1
    } if_state_e;

endpackage

// File: rtl/if_fifo.sv
// Synchronous in-order return FIFO for fetched {instr, pc} pairs.
// Flush has priority over push and pop; push on full is only taken with a pop.
module if_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign rdata = mem_q[rptr_q];

    always_comb begin
        do_pop  = pop & ~empty & ~flush;
        do_push = push & ~flush & (~full | do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
        if (do_push) wptr_d = wptr_q + PW'(1);
        if (do_pop)  rptr_d = rptr_q + PW'(1);
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request issue, redirect and wrong-path discard.
// Define IF_MISALIGN_CHK_EN to trap misaligned redirects into a sticky HALT.
import if_stage_pkg::*;

module if_stage #(
    parameter int                   WORD_SIZE  = 32,
    parameter int                   ADDR_SIZE  = 10,
    parameter logic [WORD_SIZE-1:0] RESET_PC   = '0,
    parameter int                   FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_req,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic                 imem_ready,
    input  logic                 imem_rvalid,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 id_ready,
    output logic                 fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = 2 * WORD_SIZE;

    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [CW-1:0]        outst_q, outst_d;
    logic [CW-1:0]        disc_q, disc_d;
    if_state_e            state_q, state_d;
    logic                 live_q;

    logic [CW-1:0]        fifo_cnt;
    logic                 fifo_full, fifo_empty;
    logic [FW-1:0]        fifo_wdata, fifo_rdata;

    logic                 issue, resp, drop, push, pop, misalign;
    logic [CW:0]          inflight;
    logic [WORD_SIZE-1:0] tgt_pc, resp_pc;

    assign imem_addr = pc_q[ADDR_SIZE+1:2];

    always_comb begin
        misalign = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
        misalign = redirect & (redirect_pc[1:0] != 2'b00);
`endif
        tgt_pc   = redirect_pc & ~WORD_SIZE'(3);
        inflight = {1'b0, outst_q} + {1'b0, fifo_cnt};
        // live_q keeps the first request one cycle clear of reset
        imem_req = live_q & (state_q == IF_RUN) & ~fifo_full
                 & (inflight < (CW+1)'(FIFO_DEPTH)) & ~redirect;
        issue    = imem_req & imem_ready;
        resp     = imem_rvalid & (outst_q != '0);
        drop     = resp & (redirect | (disc_q != '0) | (state_q != IF_RUN));
        push     = resp & ~drop;
        // oldest kept request sits outst_q words behind the current PC
        resp_pc  = pc_q - (WORD_SIZE'(outst_q) << 2);
        fifo_wdata = {imem_rdata, resp_pc};
        instr_valid = ~fifo_empty & ~redirect & (state_q == IF_RUN);
        pop      = instr_valid & id_ready;
        instr    = fifo_empty ? WORD_SIZE'(NOP_INSTR)
                              : fifo_rdata[FW-1:WORD_SIZE];
        instr_pc = fifo_empty ? '0 : fifo_rdata[WORD_SIZE-1:0];
    end

    always_comb begin
        pc_d    = pc_q;
        outst_d = outst_q + CW'(issue) - CW'(resp);
        disc_d  = disc_q;
        state_d = state_q;
        if (redirect) begin
            disc_d = outst_q - CW'(resp);
            if (misalign) state_d = IF_HALT;
            else          pc_d    = tgt_pc;
        end else begin
            if (resp && (disc_q != '0)) disc_d = disc_q - CW'(1);
            if (issue) pc_d = pc_q + WORD_SIZE'(4);
        end
    end

`ifdef IF_MISALIGN_CHK_EN
    assign fetch_fault = (state_q == IF_HALT);
`else
    assign fetch_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q    <= RESET_PC;
            outst_q <= '0;
            disc_q  <= '0;
            state_q <= IF_RUN;
            live_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            outst_q <= outst_d;
            disc_q  <= disc_d;
            state_q <= state_d;
            live_q  <= 1'b1;
        end
    end

    if_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an in-order variable-latency imem model.
// Covers reset, streaming, stalls, redirects, PC wrap and misaligned redirects.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        id_ready;
    logic        fetch_fault;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int lat = 1;

    logic [9:0]  mq_addr[$];
    int          mq_due[$];
    logic [9:0]  req_log[$];
    logic [31:0] hand_pc[$];
    logic [31:0] hand_ins[$];

    always #5 clk = ~clk;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .id_ready    (id_ready),
        .fetch_fault (fetch_fault)
    );

    function automatic logic [31:0] mem_data(input logic [9:0] a);
        return 32'hBEEF_0000 | {22'd0, a};
    endfunction

    function automatic logic [31:0] hp(input int i);
        return (i < hand_pc.size()) ? hand_pc[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] hi(input int i);
        return (i < hand_ins.size()) ? hand_ins[i] : 32'hDEAD_DEAD;
    endfunction

    function automatic logic [31:0] ra(input int i);
        return (i < req_log.size()) ? {22'd0, req_log[i]} : 32'hDEAD_DEAD;
    endfunction

    task automatic cycle();
        logic [9:0] a;
        int d;
        #1;
        if (imem_rvalid) begin
            a = mq_addr.pop_front();
            d = mq_due.pop_front();
        end
        if (imem_req && imem_ready) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + lat);
            req_log.push_back(imem_addr);
        end
        if (instr_valid && id_ready) begin
            hand_pc.push_back(instr_pc);
            hand_ins.push_back(instr);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_data(mq_addr[0]);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_logs();
        req_log.delete();
        hand_pc.delete();
        hand_ins.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        run(2);
        rst = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++;
            $display("FAIL rst_req got=%b exp=0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin failures++;
            $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        checks++; if (instr !== 32'h0000_0013) begin failures++;
            $display("FAIL rst_instr got=%h exp=00000013", instr); end
        checks++; if (instr_pc !== 32'h0) begin failures++;
            $display("FAIL rst_pc got=%h exp=0", instr_pc); end
        checks++; if (fetch_fault !== 1'b0) begin failures++;
            $display("FAIL rst_fault got=%b exp=0", fetch_fault); end
        cycle();
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 10'h0) begin failures++;
            $display("FAIL first_req got=%b/%h exp=1/000", imem_req, imem_addr); end
    endtask

    task automatic test_stream();
        lat = 1;
        id_ready = 1'b1;
        do_reset();
        imem_ready = 1'b0;
        run(3);
        imem_ready = 1'b1;
        run(16);
        for (int i = 0; i < 4; i++) begin
            checks++; if (ra(i) !== i) begin failures++;
                $display("FAIL stream_addr%0d got=%h exp=%h", i, ra(i), i); end
            checks++; if (hp(i) !== 4 * i) begin failures++;
                $display("FAIL stream_pc%0d got=%h exp=%h", i, hp(i), 4 * i); end
            checks++; if (hi(i) !== mem_data(10'(i))) begin failures++;
                $display("FAIL stream_ins%0d got=%h exp=%h", i, hi(i), mem_data(10'(i))); end
        end
    endtask

    task automatic test_stall();
        lat = 1;
        id_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (instr_valid) begin
                checks++;
                if (instr_pc !== 32'h0 || instr !== mem_data(10'h0)) begin failures++;
                    $display("FAIL stall_head got=%h/%h exp=0/%h", instr_pc, instr, mem_data(10'h0)); end
            end
        end
        checks++; if (req_log.size() > 2) begin failures++;
            $display("FAIL stall_issues got=%0d exp<=2", req_log.size()); end
        checks++; if (hand_pc.size() != 0) begin failures++;
            $display("FAIL stall_handoff got=%0d exp=0", hand_pc.size()); end
        id_ready = 1'b1;
        run(12);
        for (int i = 0; i < 5; i++) begin
            checks++; if (hp(i) !== 4 * i) begin failures++;
                $display("FAIL stall_pc%0d got=%h exp=%h", i, hp(i), 4 * i); end
        end
    endtask

    task automatic test_redirect_stale();
        lat = 3;
        id_ready = 1'b1;
        do_reset();
        run(3);
        checks++; if (req_log.size() != 2 || imem_rvalid !== 1'b0) begin failures++;
            $display("FAIL stale_pre got=%0d/%b exp=2/0", req_log.size(), imem_rvalid); end
        redirect = 1'b1;
        redirect_pc = 32'h40;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++;
            $display("FAIL stale_req got=%b exp=0", imem_req); end
        cycle();
        redirect = 1'b0;
        run(20);
        checks++; if (ra(2) !== 32'h10) begin failures++;
            $display("FAIL stale_addr got=%h exp=010", ra(2)); end
        checks++; if (hp(0) !== 32'h40) begin failures++;
            $display("FAIL stale_pc0 got=%h exp=40", hp(0)); end
        checks++; if (hi(0) !== mem_data(10'h10)) begin failures++;
            $display("FAIL stale_ins0 got=%h exp=%h", hi(0), mem_data(10'h10)); end
        checks++; if (hp(1) !== 32'h44) begin failures++;
            $display("FAIL stale_pc1 got=%h exp=44", hp(1)); end
    endtask

    task automatic test_redirect_coincident();
        bit found = 1'b0;
        lat = 1;
        id_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            if (instr_valid && imem_rvalid) found = 1'b1;
        end
        checks++; if (!found) begin failures++;
            $display("FAIL coinc_setup got=0 exp=1"); end
        id_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h80;
        #1;
        checks++; if (instr_valid !== 1'b0) begin failures++;
            $display("FAIL coinc_valid got=%b exp=0", instr_valid); end
        cycle();
        redirect = 1'b0;
        checks++; if (hand_pc.size() != 0) begin failures++;
            $display("FAIL coinc_handoff got=%0d exp=0", hand_pc.size()); end
        run(15);
        checks++; if (hp(0) !== 32'h80) begin failures++;
            $display("FAIL coinc_pc0 got=%h exp=80", hp(0)); end
        checks++; if (hi(0) !== mem_data(10'h20)) begin failures++;
            $display("FAIL coinc_ins0 got=%h exp=%h", hi(0), mem_data(10'h20)); end
        checks++; if (hp(1) !== 32'h84) begin failures++;
            $display("FAIL coinc_pc1 got=%h exp=84", hp(1)); end
    endtask

    task automatic test_wrap_and_reset();
        lat = 1;
        id_ready = 1'b1;
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        run(12);
        checks++; if (ra(0) !== 32'h3FF) begin failures++;
            $display("FAIL wrap_addr0 got=%h exp=3ff", ra(0)); end
        checks++; if (ra(1) !== 32'h0) begin failures++;
            $display("FAIL wrap_addr1 got=%h exp=0", ra(1)); end
        checks++; if (hp(0) !== 32'hFFFF_FFFC) begin failures++;
            $display("FAIL wrap_pc0 got=%h exp=fffffffc", hp(0)); end
        checks++; if (hp(1) !== 32'h0 || hi(1) !== mem_data(10'h0)) begin failures++;
            $display("FAIL wrap_pc1 got=%h/%h exp=0/%h", hp(1), hi(1), mem_data(10'h0)); end
        lat = 3;
        run(6);
        do_reset();
        run(20);
        checks++; if (ra(0) !== 32'h0) begin failures++;
            $display("FAIL mid_addr0 got=%h exp=0", ra(0)); end
        checks++; if (hp(0) !== 32'h0 || hi(0) !== mem_data(10'h0)) begin failures++;
            $display("FAIL mid_pc0 got=%h/%h exp=0/%h", hp(0), hi(0), mem_data(10'h0)); end
        checks++; if (hp(1) !== 32'h4) begin failures++;
            $display("FAIL mid_pc1 got=%h exp=4", hp(1)); end
    endtask

    task automatic test_misalign();
        lat = 1;
        id_ready = 1'b1;
        do_reset();
        run(4);
        clear_logs();
        redirect = 1'b1;
        redirect_pc = 32'h42;
        cycle();
        redirect = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
        for (int i = 0; i < 6; i++) begin
            cycle();
            #1;
            checks++;
            if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL halt_c%0d got=%b%b%b exp=100", i, fetch_fault, imem_req, instr_valid);
            end
        end
        checks++; if (req_log.size() != 0) begin failures++;
            $display("FAIL halt_issues got=%0d exp=0", req_log.size()); end
        do_reset();
        #1;
        checks++; if (fetch_fault !== 1'b0) begin failures++;
            $display("FAIL halt_clear got=%b exp=0", fetch_fault); end
`else
        run(12);
        checks++; if (fetch_fault !== 1'b0) begin failures++;
            $display("FAIL mis_fault got=%b exp=0", fetch_fault); end
        checks++; if (hp(0) !== 32'h40) begin failures++;
            $display("FAIL mis_pc0 got=%h exp=40", hp(0)); end
        checks++; if (hi(0) !== mem_data(10'h10)) begin failures++;
            $display("FAIL mis_ins0 got=%h exp=%h", hi(0), mem_data(10'h10)); end
`endif
    endtask

    initial begin
        rst = 1'b0;
        imem_ready = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        id_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_redirect_stale();
        test_redirect_coincident();
        test_wrap_and_reset();
        test_misalign();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
